// File: rtl/loopback_pkg.sv
// Shared constants and types for the counter loopback generator/checker pair.
package loopback_pkg;
    localparam int DATA_W         = 8;
    localparam int LOCK_CNT_DEF   = 4;
    localparam int UNLOCK_CNT_DEF = 8;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } lock_state_t;

    // Counter words wrap naturally at DATA_W bits.
    function automatic logic [DATA_W-1:0] next_word(input logic [DATA_W-1:0] w);
        return w + 1'b1;
    endfunction
endpackage

// File: rtl/counter_datacheck_if.sv
// Data/stat bundle between the loopback source (master) and the checker (slave).
interface counter_datacheck_if;
    import loopback_pkg::*;

    logic [DATA_W-1:0] data_in;
    logic              data_valid;
    logic              clear;
    logic              locked;
    logic              err_pulse;
    logic [15:0]       err_count;
    logic [31:0]       word_count;

    modport master (
        output data_in, data_valid, clear,
        input  locked, err_pulse, err_count, word_count
    );

    modport slave (
        input  data_in, data_valid, clear,
        output locked, err_pulse, err_count, word_count
    );
endinterface

// File: rtl/counter_datacheck_sat_counter.sv
// Up-counter that sticks at all-ones; clear wins over inc.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (clear)
            cnt_q <= '0;
        else if (inc)
            cnt_q <= (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    end

    assign count = cnt_q;
endmodule

// File: rtl/counter_datacheck.sv
// Loopback counter checker: hunts for an incrementing sequence, then counts mismatches.
// Define DATACHECK_WORDCNT_EN to build the 32-bit valid-word counter; otherwise word_count is 0.
module counter_datacheck
    import loopback_pkg::*;
#(
    parameter int LOCK_CNT   = LOCK_CNT_DEF,
    parameter int UNLOCK_CNT = UNLOCK_CNT_DEF
) (
    input logic                clk,
    input logic                rst,
    counter_datacheck_if.slave bus
);
    localparam int RUN_W = $clog2(LOCK_CNT + 1);
    localparam int BAD_W = $clog2(UNLOCK_CNT + 1);

    lock_state_t       state_q, state_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic              seeded_q, seeded_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [BAD_W-1:0]  bad_q, bad_d;
    logic              err_inc;
    logic              pulse_q;
    logic [15:0]       err_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= HUNT;
            prev_q   <= '0;
            seeded_q <= 1'b0;
            run_q    <= '0;
            bad_q    <= '0;
            pulse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            seeded_q <= seeded_d;
            run_q    <= run_d;
            bad_q    <= bad_d;
            pulse_q  <= err_inc;
        end
    end

    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        seeded_d = seeded_q;
        run_d    = run_q;
        bad_d    = bad_q;
        err_inc  = 1'b0;
        if (bus.data_valid) begin
            case (state_q)
                HUNT: begin
                    prev_d   = bus.data_in;
                    seeded_d = 1'b1;
                    if (seeded_q && (bus.data_in == next_word(prev_q))) begin
                        run_d = run_q + 1'b1;
                        if (run_d == RUN_W'(LOCK_CNT)) begin
                            state_d = LOCK;
                            run_d   = '0;
                            bad_d   = '0;
                        end
                    end else begin
                        run_d = '0;
                    end
                end
                LOCK: begin
                    // Expected free-runs so a single corrupted word costs one error only.
                    prev_d = next_word(prev_q);
                    if (bus.data_in != prev_d) begin
                        err_inc = 1'b1;
                        bad_d   = bad_q + 1'b1;
                        if (bad_d == BAD_W'(UNLOCK_CNT)) begin
                            state_d = HUNT;
                            prev_d  = bus.data_in;
                            bad_d   = '0;
                            run_d   = '0;
                        end
                    end else begin
                        bad_d = '0;
                    end
                end
            endcase
        end
    end

    sat_counter #(.WIDTH(16)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (err_inc),
        .clear (bus.clear),
        .count (err_count)
    );

    assign bus.locked    = (state_q == LOCK);
    assign bus.err_pulse = pulse_q;
    assign bus.err_count = err_count;

`ifdef DATACHECK_WORDCNT_EN
    logic [31:0] word_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            word_cnt_q <= '0;
        else if (bus.clear)
            word_cnt_q <= '0;
        else if (bus.data_valid)
            word_cnt_q <= word_cnt_q + 1'b1;
    end

    assign bus.word_count = word_cnt_q;
`else
    assign bus.word_count = '0;
`endif
endmodule

// File: tb/tb_counter_datacheck.sv
// Self-checking bench for counter_datacheck: directed vectors, corner sequences, random stream vs model.
module tb_counter_datacheck;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    counter_datacheck_if bus();

    counter_datacheck #(.LOCK_CNT(4), .UNLOCK_CNT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic       s_inc = 1'b0;
    logic       s_clr = 1'b0;
    logic [3:0] s_cnt;
    sat_counter #(.WIDTH(4)) u_sat (
        .clk   (clk),
        .rst   (rst),
        .inc   (s_inc),
        .clear (s_clr),
        .count (s_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state, kept in spec terms.
    bit          m_locked, m_seeded, m_pulse;
    int          m_prev, m_run, m_bad, m_err;
    logic [31:0] m_wc;

    typedef struct {
        bit         valid;
        logic [7:0] data;
        bit         clr;
        bit         exp_locked;
        bit         exp_pulse;
        int         exp_err;
    } vec_t;
    vec_t tbl[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_wc(input logic [31:0] v);
`ifdef DATACHECK_WORDCNT_EN
        return v;
`else
        return (v & 32'h0);
`endif
    endfunction

    task automatic model_reset();
        m_locked = 0; m_seeded = 0; m_pulse = 0;
        m_prev = 0; m_run = 0; m_bad = 0; m_err = 0; m_wc = 0;
    endtask

    task automatic model_step(input bit v, input logic [7:0] d, input bit clr);
        m_pulse = 0;
        if (v) begin
            if (!m_locked) begin
                if (m_seeded && int'(d) == ((m_prev + 1) % 256)) begin
                    m_run++;
                    if (m_run == 4) begin m_locked = 1; m_bad = 0; m_run = 0; end
                end else begin
                    m_run = 0;
                end
                m_prev = d;
                m_seeded = 1;
            end else begin
                m_prev = (m_prev + 1) % 256;
                if (int'(d) != m_prev) begin
                    m_pulse = 1;
                    if (m_err < 65535) m_err++;
                    m_bad++;
                    if (m_bad == 8) begin
                        m_locked = 0; m_prev = d; m_run = 0; m_bad = 0; m_seeded = 1;
                    end
                end else begin
                    m_bad = 0;
                end
            end
            m_wc = m_wc + 1;
        end
        if (clr) begin m_err = 0; m_wc = 0; end
    endtask

    task automatic check_model();
        chk("locked", 32'(bus.locked), 32'(m_locked));
        chk("err_pulse", 32'(bus.err_pulse), 32'(m_pulse));
        chk("err_count", 32'(bus.err_count), m_err);
        chk("word_count", bus.word_count, exp_wc(m_wc));
    endtask

    // Entered and left just after a falling edge.
    task automatic cycle(input bit v, input logic [7:0] d, input bit clr);
        bus.data_valid = v;
        bus.data_in    = d;
        bus.clear      = clr;
        model_step(v, d, clr);
        @(posedge clk);
        #1;
        check_model();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.data_valid = 1'b0;
        bus.clear = 1'b0;
        #1;
        model_reset();
        check_model();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int pulses;
        int gen;
        bus.data_in = 8'h00;
        bus.data_valid = 1'b0;
        bus.clear = 1'b0;
        @(negedge clk);
        do_reset();

        // Lock acquisition on 0x00..0x10, then idle, clear and continuation.
        for (int i = 0; i < 17; i++)
            tbl[i] = '{1'b1, 8'(i), 1'b0, (i >= 4), 1'b0, 0};
        tbl[17] = '{1'b0, 8'hAA, 1'b0, 1'b1, 1'b0, 0};
        tbl[18] = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 0};
        tbl[19] = '{1'b1, 8'h77, 1'b0, 1'b1, 1'b1, 1};
        for (int i = 0; i < 20; i++) begin
            cycle(tbl[i].valid, tbl[i].data, tbl[i].clr);
            chk($sformatf("tbl%0d_locked", i), 32'(bus.locked), 32'(tbl[i].exp_locked));
            chk($sformatf("tbl%0d_pulse", i), 32'(bus.err_pulse), 32'(tbl[i].exp_pulse));
            chk($sformatf("tbl%0d_err", i), 32'(bus.err_count), tbl[i].exp_err);
        end

        // Wrap 0xFF -> 0x00 while locked, then single corrupted word.
        do_reset();
        for (int w = 8'hF8; w <= 8'hFF; w++) cycle(1'b1, 8'(w), 1'b0);
        chk("wrap_locked_pre", 32'(bus.locked), 32'd1);
        pulses = 0;
        for (int w = 0; w <= 8'h21; w++) begin
            cycle(1'b1, 8'(w), 1'b0);
            pulses += int'(bus.err_pulse);
        end
        chk("wrap_pulses", pulses, 0);
        chk("wrap_err", 32'(bus.err_count), 32'd0);
        cycle(1'b1, 8'h55, 1'b0);
        chk("bad_word_pulse", 32'(bus.err_pulse), 32'd1);
        cycle(1'b1, 8'h23, 1'b0);
        chk("bad_word_err", 32'(bus.err_count), 32'd1);
        chk("bad_word_locked", 32'(bus.locked), 32'd1);
        chk("bad_word_pulse_gone", 32'(bus.err_pulse), 32'd0);

        // Dropped word: eight errors, unlock, then relock on the fourth in-sequence word.
        cycle(1'b1, 8'h24, 1'b1);
        chk("clear_err", 32'(bus.err_count), 32'd0);
        for (int w = 8'h25; w <= 8'h2F; w++) cycle(1'b1, 8'(w), 1'b0);
        pulses = 0;
        for (int w = 8'h31; w <= 8'h38; w++) begin
            cycle(1'b1, 8'(w), 1'b0);
            pulses += int'(bus.err_pulse);
        end
        chk("drop_pulses", pulses, 8);
        chk("drop_err", 32'(bus.err_count), 32'd8);
        chk("drop_unlocked", 32'(bus.locked), 32'd0);
        for (int w = 8'h39; w <= 8'h3B; w++) cycle(1'b1, 8'(w), 1'b0);
        chk("relock_early", 32'(bus.locked), 32'd0);
        cycle(1'b1, 8'h3C, 1'b0);
        chk("relock", 32'(bus.locked), 32'd1);

        // Saturation at 0xFFFF and clear beating a same-cycle error.
        force dut.u_err_cnt.cnt_q = 16'hFFFF;
        m_err = 65535;
        cycle(1'b1, 8'h00, 1'b0);
        release dut.u_err_cnt.cnt_q;
        #1;
        chk("sat_hold", 32'(bus.err_count), 32'hFFFF);
        cycle(1'b1, 8'h99, 1'b0);
        chk("sat_stay", 32'(bus.err_count), 32'hFFFF);
        cycle(1'b1, 8'h3F, 1'b0);
        cycle(1'b1, 8'h11, 1'b1);
        chk("clear_vs_err_pulse", 32'(bus.err_pulse), 32'd1);
        chk("clear_vs_err", 32'(bus.err_count), 32'd0);
        chk("clear_keeps_lock", 32'(bus.locked), 32'd1);

        // Asynchronous reset while locked.
        chk("pre_rst_locked", 32'(bus.locked), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_locked", 32'(bus.locked), 32'd0);
        chk("async_rst_pulse", 32'(bus.err_pulse), 32'd0);
        chk("async_rst_err", 32'(bus.err_count), 32'd0);
        chk("async_rst_wc", bus.word_count, 32'd0);
        @(negedge clk);
        do_reset();
        // First word after release only seeds: 0x81 after 0x80 is run 1 of 4.
        for (int w = 8'h80; w <= 8'h83; w++) cycle(1'b1, 8'(w), 1'b0);
        chk("seed_after_rst", 32'(bus.locked), 32'd0);
        for (int w = 8'h84; w < 8'h80 + 100; w++) cycle(1'b1, 8'(w), 1'b0);
        chk("wc_after_100", bus.word_count, exp_wc(32'd100));

        // Standalone saturating counter at a narrow width.
        do_reset();
        s_inc = 1'b1;
        repeat (15) @(negedge clk);
        chk("sat4_at_15", 32'(s_cnt), 32'd15);
        repeat (5) @(negedge clk);
        chk("sat4_stuck", 32'(s_cnt), 32'd15);
        s_clr = 1'b1;
        @(negedge clk);
        chk("sat4_clear", 32'(s_cnt), 32'd0);
        s_clr = 1'b0;
        s_inc = 1'b0;

        // Randomized loopback stream with drops, corruption, idles and clears.
        do_reset();
        gen = $urandom_range(0, 255);
        for (int i = 0; i < 3000; i++) begin
            bit         v;
            bit         clr;
            int         r;
            logic [7:0] d;
            v = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 99);
            clr = ($urandom_range(0, 199) == 0);
            if (r < 3) begin
                d = 8'($urandom);
            end else if (r < 5) begin
                gen = (gen + 1) % 256;
                d = 8'(gen);
            end else begin
                d = 8'(gen);
            end
            cycle(v, d, clr);
            if (v) gen = (gen + 1) % 256;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/counter_datacheck.md
COUNTER_DATACHECK -- requirements
Module: counter_datacheck

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 4: consecutive in-sequence words required to enter LOCK.
REQ-002 SHALL have parameter UNLOCK_CNT, default 8: consecutive mismatches in LOCK that force a return to HUNT.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port data_in, input, 8: received counter word, the looped-back output of the counter generator.
REQ-006 SHALL have port data_valid, input, 1: data_in is sampled on a clk edge only when this is 1.
REQ-007 SHALL have port clear, input, 1: synchronous clear of the statistics counters.
REQ-008 SHALL have port locked, output, 1: high while in LOCK.
REQ-009 SHALL have port err_pulse, output, 1: one-cycle pulse per mismatching word in LOCK.
REQ-010 SHALL have port err_count, output, 16: saturating mismatch count.
REQ-011 SHALL have port word_count, output, 32: valid words received.

Function
REQ-012 SHALL use two states, HUNT and LOCK; all outputs are registered and change 1 cycle after the sampling edge.
REQ-013 SHALL define expected-next as (previous sampled word + 1) mod 256, so 0xFF is followed by 0x00 with no error.
REQ-014 In HUNT, the first valid word after reset or unlock SHALL only seed the previous-word register; run = 0.
REQ-015 In HUNT, each valid word equal to expected-next SHALL increment run, and any other word SHALL reset run to 0 and reseed.
REQ-016 SHALL transition HUNT->LOCK on the edge where run reaches LOCK_CNT; locked rises on the following cycle.
REQ-017 In LOCK, expected SHALL advance by 1 on every valid word whether it matched or not (free-running), so one corrupted word yields exactly one error.
REQ-018 In LOCK, a mismatch SHALL assert err_pulse, increment err_count (saturating at 0xFFFF) and increment bad_run; a match SHALL reset bad_run to 0.
REQ-019 SHALL transition LOCK->HUNT when bad_run reaches UNLOCK_CNT; the word that causes this is counted as an error and seeds the next HUNT.
REQ-020 When data_valid = 0, state, run, bad_run and expected SHALL hold, and err_pulse SHALL be 0.
REQ-021 No error SHALL ever be counted in HUNT.
REQ-022 clear SHALL zero err_count and word_count on the next edge, SHALL take priority over a same-cycle increment, and SHALL NOT affect state or lock.
REQ-023 word_count SHALL wrap modulo 2^32.

Reset
REQ-024 Asserting rst SHALL immediately force: state HUNT, locked 0, err_pulse 0, err_count 0, word_count 0, run 0, bad_run 0, previous-word 0x00, seeded flag 0.
REQ-025 On reset release mid-stream, the first valid word SHALL be treated as a seed (REQ-014).

Configuration
REQ-026 With macro DATACHECK_WORDCNT_EN defined, the 32-bit word_count counter SHALL be implemented per REQ-011/022/023.
REQ-027 Without DATACHECK_WORDCNT_EN, word_count SHALL be tied to constant 0 and no counter register inferred; all other behaviour is unchanged.

Structure
REQ-028 Package loopback_pkg SHALL hold the DATA_W = 8 constant, the HUNT/LOCK state typedef, and the default LOCK_CNT/UNLOCK_CNT constants shared with the generator.
REQ-029 err_count SHALL be built from one sub-module, sat_counter (parameterised width, inc/clear inputs, saturates at all-ones).

Verification
REQ-030 Reset, then stream 0x00..0x10 valid every cycle -> locked = 1 one cycle after the 5th word (0x04); err_count = 0.
REQ-031 Locked stream 0xFD,0xFE,0xFF,0x00,0x01 -> no err_pulse at wrap.
REQ-032 Locked stream 0x20,0x21,0x55,0x23 -> exactly one err_pulse (for 0x55), err_count = 1, locked stays 1.
REQ-033 Locked, drop word 0x30 (stream 0x2F,0x31,0x32,...) -> 8 consecutive err_pulse, err_count = 8, locked = 0, then relock after 4 more in-sequence words.
REQ-034 Force err_count to 0xFFFF, then inject an error -> stays 0xFFFF; assert clear together with an error -> err_count = 0.
REQ-035 Assert rst mid-stream while locked -> all outputs 0 asynchronously; with DATACHECK_WORDCNT_EN undefined, word_count = 0 after 100 valid words.
